// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break).
package mem_arbiter_pkg;

   // FSM state encodings
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Transaction owner encodings
   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection between IFU and LSU.
// MEM_ARB_RR_EN defined: ties go to the master that did not win last.
// MEM_ARB_RR_EN undefined: ties always go to the LSU.
import mem_arbiter_pkg::*;

module arb_pick (
   input  logic   ifu_valid,
   input  logic   lsu_valid,
   input  owner_e last_owner,
   output logic   grant_ifu,
   output logic   grant_lsu
);

`ifndef MEM_ARB_RR_EN
   // Fixed priority does not look at the history input.
   logic unused_last_owner;
   assign unused_last_owner = last_owner;
`endif

   // Pick at most one winner; a lone requester always wins.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
         grant_lsu = (last_owner == OWN_IFU);
         grant_ifu = (last_owner == OWN_LSU);
`else
         grant_lsu = 1'b1;
`endif
      end else begin
         grant_ifu = ifu_valid;
         grant_lsu = lsu_valid;
      end
   end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port, one transaction
// outstanding at a time. Optional macro: MEM_ARB_RR_EN (round-robin ties).
import mem_arbiter_pkg::*;

module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   // IFU master
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   input  logic                  ifu_wen,
   input  logic [DATA_W-1:0]     ifu_wdata,
   input  logic [DATA_W/8-1:0]   ifu_wmask,
   output logic                  ifu_resp_valid,
   output logic [DATA_W-1:0]     ifu_resp_data,
   // LSU master
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wmask,
   output logic                  lsu_resp_valid,
   output logic [DATA_W-1:0]     lsu_resp_data,
   // Memory port
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wen,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_data
);

   localparam int unsigned MASK_W = DATA_W / 8;

   arb_state_e state;
   owner_e     owner;
   owner_e     pick_history;
   logic       grant_ifu;
   logic       grant_lsu;

`ifdef MEM_ARB_RR_EN
   owner_e     last_owner;
   assign pick_history = last_owner;
`else
   assign pick_history = OWN_IFU;
`endif

   arb_pick u_pick (
      .ifu_valid  (ifu_req_valid),
      .lsu_valid  (lsu_req_valid),
      .last_owner (pick_history),
      .grant_ifu  (grant_ifu),
      .grant_lsu  (grant_lsu)
   );

   // Grant is only visible while idle and out of reset.
   assign ifu_req_ready = (state == ARB_IDLE) && !rst && grant_ifu;
   assign lsu_req_ready = (state == ARB_IDLE) && !rst && grant_lsu;

   // Arbitration FSM with payload latch and response routing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ARB_IDLE;
         owner          <= OWN_IFU;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= MASK_W'(0);
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         ifu_resp_data  <= '0;
         lsu_resp_data  <= '0;
`ifdef MEM_ARB_RR_EN
         last_owner     <= OWN_IFU;
`endif
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_lsu) begin
                  owner         <= OWN_LSU;
                  mem_addr      <= lsu_addr;
                  mem_wen       <= lsu_wen;
                  mem_wdata     <= lsu_wdata;
                  mem_wmask     <= lsu_wmask;
                  mem_req_valid <= 1'b1;
                  state         <= ARB_REQ;
`ifdef MEM_ARB_RR_EN
                  last_owner    <= OWN_LSU;
`endif
               end else if (grant_ifu) begin
                  owner         <= OWN_IFU;
                  mem_addr      <= ifu_addr;
                  mem_wen       <= ifu_wen;
                  mem_wdata     <= ifu_wdata;
                  mem_wmask     <= ifu_wmask;
                  mem_req_valid <= 1'b1;
                  state         <= ARB_REQ;
`ifdef MEM_ARB_RR_EN
                  last_owner    <= OWN_IFU;
`endif
               end
            end
            ARB_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (mem_resp_valid) begin
                  // Writes return an acknowledge only; data is zeroed.
                  if (owner == OWN_LSU) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_resp_data  <= mem_wen ? '0 : mem_resp_data;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_resp_data  <= mem_wen ? '0 : mem_resp_data;
                  end
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_wen, ifu_resp_valid;
   logic [31:0] ifu_addr;
   logic [63:0] ifu_wdata, ifu_resp_data;
   logic [7:0]  ifu_wmask;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [31:0] lsu_addr;
   logic [63:0] lsu_wdata, lsu_resp_data;
   logic [7:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata, mem_resp_data;
   logic [7:0]  mem_wmask;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_wen        (ifu_wen),
      .ifu_wdata      (ifu_wdata),
      .ifu_wmask      (ifu_wmask),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_data  (ifu_resp_data),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_data  (lsu_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational ready settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   // Entered right after the accept edge: hold ready low for `waits`
   // cycles, accept, respond, and check the routed response.
   task automatic serve(input logic [31:0] ea, input logic ew, input logic [63:0] ewd,
                        input logic [7:0] ewm, input int waits, input logic [63:0] rdata,
                        input bit to_lsu, input logic [63:0] exp_data);
      for (int i = 0; i <= waits; i++) begin
         settle();
         chk("req_valid", 64'(mem_req_valid), 64'd1);
         chk("addr", 64'(mem_addr), 64'(ea));
         chk("wen", 64'(mem_wen), 64'(ew));
         chk("wdata", mem_wdata, ewd);
         chk("wmask", 64'(mem_wmask), 64'(ewm));
         chk("busy_ready", 64'(ifu_req_ready | lsu_req_ready), 64'd0);
         if (i == waits) mem_req_ready = 1'b1;
         cyc();
      end
      mem_req_ready = 1'b0;
      chk("req_valid_resp", 64'(mem_req_valid), 64'd0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      cyc();
      mem_resp_valid = 1'b0;
      chk("own_resp_valid", 64'(to_lsu ? lsu_resp_valid : ifu_resp_valid), 64'd1);
      chk("other_resp_valid", 64'(to_lsu ? ifu_resp_valid : lsu_resp_valid), 64'd0);
      chk("resp_data", to_lsu ? lsu_resp_data : ifu_resp_data, exp_data);
   endtask

   initial begin
      bit exp_lsu;
      rst = 1'b1;
      ifu_req_valid = 0; ifu_addr = 0; ifu_wen = 0; ifu_wdata = 0; ifu_wmask = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
      cyc(); cyc();

      // Reset state, including no grant while reset is held.
      ifu_req_valid = 1'b1;
      settle();
      chk("rst_ifu_ready", 64'(ifu_req_ready), 64'd0);
      chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_resp_valid", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      chk("rst_ifu_data", ifu_resp_data, 64'd0);
      chk("rst_lsu_data", lsu_resp_data, 64'd0);
      ifu_req_valid = 1'b0;
      rst = 1'b0;
      cyc();

      // IFU read alone, zero-wait memory.
      ifu_req_valid = 1'b1;
      ifu_addr = 32'h8000_0000;
      settle();
      chk("t1_ifu_ready", 64'(ifu_req_ready), 64'd1);
      chk("t1_lsu_ready", 64'(lsu_req_ready), 64'd0);
      cyc();
      ifu_req_valid = 1'b0;
      serve(32'h8000_0000, 1'b0, 64'd0, 8'd0, 0, 64'h1122_3344_5566_7788, 1'b0,
            64'h1122_3344_5566_7788);
      cyc();
      chk("t1_pulse_one_cycle", 64'(ifu_resp_valid), 64'd0);
      chk("t1_data_hold", ifu_resp_data, 64'h1122_3344_5566_7788);

      // Tie-break after a fresh reset, three back-to-back transactions.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h200;
      lsu_req_valid = 1'b1; lsu_addr = 32'h100;
      for (int t = 0; t < 3; t++) begin
`ifdef MEM_ARB_RR_EN
         exp_lsu = (t != 1);
`else
         exp_lsu = 1'b1;
`endif
         settle();
         chk("tie_lsu_ready", 64'(lsu_req_ready), 64'(exp_lsu));
         chk("tie_ifu_ready", 64'(ifu_req_ready), 64'(!exp_lsu));
         cyc();
         serve(exp_lsu ? 32'h100 : 32'h200, 1'b0, 64'd0, 8'd0, 0, 64'(100 + t),
               exp_lsu, 64'(100 + t));
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      cyc();

      // LSU write with memory stalling for 3 cycles.
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
      lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
      settle();
      chk("wr_lsu_ready", 64'(lsu_req_ready), 64'd1);
      cyc();
      lsu_req_valid = 1'b0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      serve(32'h8000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 64'hFFFF_FFFF_FFFF_FFFF,
            1'b1, 64'd0);
      cyc();

      // IFU request arriving while LSU transaction sits in RESP.
      lsu_req_valid = 1'b1; lsu_addr = 32'h300;
      cyc();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h400;
      settle();
      chk("busy_resp_ifu_ready0", 64'(ifu_req_ready), 64'd0);
      cyc();
      chk("busy_resp_ifu_ready1", 64'(ifu_req_ready), 64'd0);
      mem_resp_valid = 1'b1; mem_resp_data = 64'h55;
      cyc();
      mem_resp_valid = 1'b0;
      chk("busy_lsu_resp", 64'(lsu_resp_valid), 64'd1);
      chk("busy_lsu_data", lsu_resp_data, 64'h55);
      chk("busy_ifu_granted", 64'(ifu_req_ready), 64'd1);
      cyc();
      ifu_req_valid = 1'b0;
      serve(32'h400, 1'b0, 64'd0, 8'd0, 1, 64'h66, 1'b0, 64'h66);
      cyc();

      // Reset asserted while in RESP abandons the transaction.
      lsu_req_valid = 1'b1; lsu_addr = 32'h500;
      cyc();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
      cyc();
      rst = 1'b0;
      mem_resp_valid = 1'b0;
      chk("rr_resp_valid", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      chk("rr_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rr_mem_addr", 64'(mem_addr), 64'd0);
      chk("rr_lsu_data", lsu_resp_data, 64'd0);
      chk("rr_ifu_data", ifu_resp_data, 64'd0);
      cyc();
      chk("rr_no_late_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      ifu_req_valid = 1'b1; ifu_addr = 32'h600;
      settle();
      chk("rr_new_grant", 64'(ifu_req_ready), 64'd1);
      cyc();
      ifu_req_valid = 1'b0;
      serve(32'h600, 1'b0, 64'd0, 8'd0, 0, 64'h88, 1'b0, 64'h88);
      cyc();

      // Spurious memory responses in IDLE and REQ are ignored.
      mem_resp_valid = 1'b1; mem_resp_data = 64'h99;
      cyc();
      mem_resp_valid = 1'b0;
      chk("sp_idle_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      chk("sp_idle_req_valid", 64'(mem_req_valid), 64'd0);
      lsu_req_valid = 1'b1; lsu_addr = 32'h700;
      settle();
      chk("sp_idle_still_grants", 64'(lsu_req_ready), 64'd1);
      cyc();
      lsu_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 64'hAA;
      cyc();
      mem_resp_valid = 1'b0;
      chk("sp_req_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      chk("sp_req_still_req", 64'(mem_req_valid), 64'd1);
      serve(32'h700, 1'b0, 64'd0, 8'd0, 0, 64'hBB, 1'b1, 64'hBB);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
